scan_decoder: RTL and testbench

SCAN_DECODER -- requirements
Module: scan_decoder

---
 rtl/scan_decoder.sv | 146 ++++++++++++++
 tb/tb_scan_decoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : scan_decoder
//  Purpose  : Registered one-hot output decoder with direct (handshaked) and
//             auto-scan modes. Optional sticky out-of-range flag `err` when
//             macro SCAN_DECODER_ERR_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module scan_decoder #(
    parameter int SEL_W    = 2,
    parameter int NUM_OUT  = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] out,
    output logic               out_valid,
    output logic [SEL_W-1:0]   scan_idx
`ifdef SCAN_DECODER_ERR_EN
    ,
    output logic               err
`endif
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HOLD = 2'd1;
    localparam logic [1:0] c_ST_SCAN = 2'd2;

    localparam logic [NUM_OUT-1:0] c_HOT0     = {{(NUM_OUT-1){1'b0}}, 1'b1};
    localparam logic [SEL_W-1:0]   c_LAST_IDX = SEL_W'(NUM_OUT - 1);
    localparam logic [DIV_W-1:0]   c_DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [NUM_OUT-1:0] r_out;
    logic [NUM_OUT-1:0] w_out_nxt;
    logic               r_out_valid;
    logic               w_out_valid_nxt;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic [SEL_W-1:0]   w_idx_inc;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   w_div_nxt;
    logic               w_xfer;
    logic [NUM_OUT-1:0] w_sel_hot;
    logic [NUM_OUT-1:0] w_scan_hot;

    // A shift past the top bit yields zero, so out-of-range selects decode to all-zero.
    assign in_ready   = en & ~mode & rst_n;
    assign w_xfer     = in_valid & in_ready;
    assign w_sel_hot  = c_HOT0 << sel;
    assign w_idx_inc  = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
    assign w_scan_hot = c_HOT0 << w_idx_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A transfer accepted on the cycle mode drops wins over the return to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = c_ST_IDLE;
        end else if (mode) begin
            w_state_nxt = c_ST_SCAN;
        end else if (w_xfer) begin
            w_state_nxt = c_ST_HOLD;
        end else if (r_state == c_ST_SCAN) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    always_comb begin
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_idx_nxt       = r_idx;
        w_div_nxt       = r_div;
        if (!en) begin
            w_out_nxt = '0;
        end else if (mode) begin
            if (r_state != c_ST_SCAN) begin
                w_idx_nxt       = '0;
                w_div_nxt       = '0;
                w_out_nxt       = c_HOT0;
                w_out_valid_nxt = 1'b1;
            end else if (r_div == c_DIV_LAST) begin
                w_div_nxt       = '0;
                w_idx_nxt       = w_idx_inc;
                w_out_nxt       = w_scan_hot;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_div_nxt = r_div + 1'b1;
            end
        end else if (w_xfer) begin
            w_out_nxt       = w_sel_hot;
            w_out_valid_nxt = 1'b1;
        end else if (r_state == c_ST_SCAN) begin
            w_out_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_div       <= '0;
        end else begin
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_idx       <= w_idx_nxt;
            r_div       <= w_div_nxt;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign scan_idx  = r_idx;

`ifdef SCAN_DECODER_ERR_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_xfer && (w_sel_hot == '0)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scan_decoder
//  Purpose  : Directed, table-driven bench for scan_decoder (default 4-output
//             instance plus a 3-output instance for out-of-range selects).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scan_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mode, in_valid, in_ready;
    logic [1:0] sel;
    logic [3:0] out;
    logic       out_valid;
    logic [1:0] scan_idx;

    logic       b_en, b_mode, b_in_valid, b_in_ready;
    logic [1:0] b_sel;
    logic [2:0] b_out;
    logic       b_out_valid;
    logic [1:0] b_scan_idx;
`ifdef SCAN_DECODER_ERR_EN
    logic       a_err, b_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(2), .NUM_OUT(4), .SCAN_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .out(out), .out_valid(out_valid),
        .scan_idx(scan_idx)
`ifdef SCAN_DECODER_ERR_EN
        , .err(a_err)
`endif
    );

    scan_decoder #(.SEL_W(2), .NUM_OUT(3), .SCAN_DIV(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(b_en), .mode(b_mode), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out(b_out), .out_valid(b_out_valid),
        .scan_idx(b_scan_idx)
`ifdef SCAN_DECODER_ERR_EN
        , .err(b_err)
`endif
    );

    typedef struct packed {
        logic       en;
        logic       mode;
        logic       in_valid;
        logic [1:0] sel;
        logic       exp_ready;
        logic [3:0] exp_out;
        logic       exp_ov;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] hot;
        int         k;

        // en, mode, in_valid, sel, ready, out, out_valid
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 4'b0100, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 4'b0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0000, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0001, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0};

        rst_n = 1'b0; en = 1'b1; mode = 1'b0; in_valid = 1'b0; sel = 2'd0;
        b_en = 1'b0; b_mode = 1'b0; b_in_valid = 1'b0; b_sel = 2'd0;
        repeat (3) tick();
        check("rst_out", 32'(out), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_scan_idx", 32'(scan_idx), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'h1);

        for (int i = 0; i < 12; i++) begin
            en = vecs[i].en; mode = vecs[i].mode;
            in_valid = vecs[i].in_valid; sel = vecs[i].sel;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
            tick();
            check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
        end

        // Scan for 20 cycles while a stray select is offered in mode 1.
        mode = 1'b1; in_valid = 1'b1; sel = 2'd3;
        #1;
        check("scan_in_ready", 32'(in_ready), 32'h0);
        for (int c = 0; c < 20; c++) begin
            tick();
            k   = (c / 4) % 4;
            hot = 4'b0001 << k;
            check($sformatf("scan%0d_out", c), 32'(out), 32'(hot));
            check($sformatf("scan%0d_out_valid", c), 32'(out_valid), ((c % 4) == 0) ? 32'h1 : 32'h0);
            check($sformatf("scan%0d_idx", c), 32'(scan_idx), 32'(k));
        end
        in_valid = 1'b0;

        // Leave scan, restart it, then pause with en low at index 2.
        mode = 1'b0;
        tick();
        check("mode_drop_out", 32'(out), 32'h0);
        mode = 1'b1;
        repeat (9) tick();
        check("mid_scan_out", 32'(out), 32'b0100);
        check("mid_scan_idx", 32'(scan_idx), 32'h2);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("pause%0d_out", c), 32'(out), 32'h0);
            check($sformatf("pause%0d_out_valid", c), 32'(out_valid), 32'h0);
            check($sformatf("pause%0d_idx", c), 32'(scan_idx), 32'h2);
        end
        en = 1'b1;
        tick();
        check("resume_out", 32'(out), 32'b0001);
        check("resume_out_valid", 32'(out_valid), 32'h1);
        check("resume_idx", 32'(scan_idx), 32'h0);

        // Three-output instance: select 3 is out of range.
        b_en = 1'b1; b_in_valid = 1'b1; b_sel = 2'd3;
        tick();
        check("oor_out", 32'(b_out), 32'h0);
        check("oor_out_valid", 32'(b_out_valid), 32'h1);
`ifdef SCAN_DECODER_ERR_EN
        check("oor_err", 32'(b_err), 32'h1);
`endif
        b_in_valid = 1'b0;
        repeat (2) tick();
        check("oor_hold_out_valid", 32'(b_out_valid), 32'h0);
        b_in_valid = 1'b1; b_sel = 2'd1;
        tick();
        check("b_sel1_out", 32'(b_out), 32'b010);
        check("b_sel1_out_valid", 32'(b_out_valid), 32'h1);
`ifdef SCAN_DECODER_ERR_EN
        check("err_sticky", 32'(b_err), 32'h1);
`endif
        b_in_valid = 1'b0;

        // Reset landing on a transfer cycle.
        mode = 1'b0; in_valid = 1'b1; sel = 2'd1; rst_n = 1'b0;
        #1;
        check("rst_xfer_in_ready", 32'(in_ready), 32'h0);
        tick();
        check("rst_xfer_out", 32'(out), 32'h0);
        check("rst_xfer_out_valid", 32'(out_valid), 32'h0);
        check("rst_xfer_idx", 32'(scan_idx), 32'h0);
        check("rst_b_out", 32'(b_out), 32'h0);
`ifdef SCAN_DECODER_ERR_EN
        check("rst_err", 32'(b_err), 32'h0);
`endif
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        check("post_rst_out", 32'(out), 32'h0);
        check("post_rst_out_valid", 32'(out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
